// File: rtl/bnn_sched_pkg.sv
// bnn_sched_pkg
//   Shared types for the BNN conv job scheduler: scheduler FSM state encoding,
//   the queued job descriptor and the default base-address width.
//   No ports (package).
package bnn_sched_pkg;

    // Descriptor fields are sized by this constant; the scheduler's ADDR_W
    // parameter is expected to match it.
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] in_base;
        logic [ADDR_W_DEF-1:0] w_base;
        logic [ADDR_W_DEF-1:0] out_base;
    } job_desc_t;

endpackage

// File: rtl/bnn_job_scheduler_if.sv
// bnn_job_scheduler_if
//   Bundles the host job-push handshake and the conv-engine run/busy pins.
//   master : host/engine side (drives descriptors and eng_busy)
//   slave  : scheduler side (drives job_ready, eng_run, eng_*_base)
//   Signals: job_valid, job_ready, job_in_base, job_w_base, job_out_base,
//            eng_run, eng_busy, eng_in_base, eng_w_base, eng_out_base
interface bnn_job_scheduler_if
    import bnn_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              job_valid;
    logic              job_ready;
    logic [ADDR_W-1:0] job_in_base;
    logic [ADDR_W-1:0] job_w_base;
    logic [ADDR_W-1:0] job_out_base;

    logic              eng_run;
    logic              eng_busy;
    logic [ADDR_W-1:0] eng_in_base;
    logic [ADDR_W-1:0] eng_w_base;
    logic [ADDR_W-1:0] eng_out_base;

    modport master (
        output job_valid, job_in_base, job_w_base, job_out_base, eng_busy,
        input  job_ready, eng_run, eng_in_base, eng_w_base, eng_out_base
    );

    modport slave (
        input  job_valid, job_in_base, job_w_base, job_out_base, eng_busy,
        output job_ready, eng_run, eng_in_base, eng_w_base, eng_out_base
    );

endinterface

// File: rtl/bnn_job_fifo.sv
// bnn_job_fifo
//   Synchronous show-ahead FIFO of job descriptors.
//   Ports: clk, reset (sync, active-high), push, pop, din, head (entry at the
//   read pointer), full, empty, count (occupancy 0..DEPTH).
//   push while full and pop while empty are ignored.
module bnn_job_fifo
    import bnn_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  job_desc_t                    din,
    output job_desc_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    job_desc_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bnn_job_scheduler.sv
// bnn_job_scheduler
//   Queues conv jobs and launches the BNN conv engine one job at a time via
//   its run/busy handshake; reports completions and start timeouts.
//   Ports: clk, reset (sync, active-high)
//          bus        : job push handshake + engine run/busy/base addresses
//          halt       : block new launches (running job still completes)
//          err_clear  : clear sticky timeout_err (a same-cycle set wins)
//          done_pulse : one cycle per completed job
//          timeout_err: sticky, engine never raised busy after eng_run
//          jobs_done  : saturating completion counter
//          q_count    : queued, not yet launched jobs
//          sched_idle : FSM idle and queue empty
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | wait for queued job, !halt and engine not busy; pop head
//   LAUNCH    | eng_run pulse, clear start counter
//   WAIT_BUSY | wait for eng_busy; give up after START_TIMEOUT cycles
//   RUN       | engine working, wait for eng_busy to drop
//   DONE      | done_pulse, count the completion
module bnn_job_scheduler
    import bnn_sched_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DEPTH         = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    bnn_job_scheduler_if.slave          bus,
    input  logic                        halt,
    input  logic                        err_clear,
    output logic                        done_pulse,
    output logic                        timeout_err,
    output logic [15:0]                 jobs_done,
    output logic [$clog2(DEPTH+1)-1:0]  q_count,
    output logic                        sched_idle
);
    localparam int TO_W = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [TO_W-1:0]   start_cnt;
    job_desc_t         fifo_din;
    job_desc_t         fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              run_c;
    logic              done_c;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              to_set;
    logic [ADDR_W-1:0] in_base_q;
    logic [ADDR_W-1:0] w_base_q;
    logic [ADDR_W-1:0] out_base_q;

    // Gating push with !full means an offer while full is dropped even when
    // the FSM pops in the same cycle.
    assign bus.job_ready = !fifo_full;
    assign fifo_push     = bus.job_valid && !fifo_full;
    assign fifo_din      = '{in_base:  bus.job_in_base,
                             w_base:   bus.job_w_base,
                             out_base: bus.job_out_base};

    bnn_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        run_c     = 1'b0;
        done_c    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        to_set    = 1'b0;
        unique case (state)
            IDLE: begin
                // A busy engine here is residual (e.g. after reset mid-job),
                // so just hold off launching.
                if (!fifo_empty && !halt && !bus.eng_busy) begin
                    fifo_pop  = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                run_c     = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.eng_busy) begin
                    state_nxt = RUN;
                end else if (start_cnt == TO_LAST) begin
                    to_set    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RUN: begin
                if (!bus.eng_busy) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_cnt   <= '0;
            in_base_q   <= '0;
            w_base_q    <= '0;
            out_base_q  <= '0;
            timeout_err <= 1'b0;
            jobs_done   <= '0;
        end else begin
            if (cnt_clr)      start_cnt <= '0;
            else if (cnt_inc) start_cnt <= start_cnt + 1'b1;

            if (fifo_pop) begin
                in_base_q  <= fifo_head.in_base;
                w_base_q   <= fifo_head.w_base;
                out_base_q <= fifo_head.out_base;
            end

            if (to_set)         timeout_err <= 1'b1;
            else if (err_clear) timeout_err <= 1'b0;

            if (done_c && (jobs_done != 16'hFFFF)) jobs_done <= jobs_done + 16'd1;
        end
    end

    assign bus.eng_run      = run_c;
    assign bus.eng_in_base  = in_base_q;
    assign bus.eng_w_base   = w_base_q;
    assign bus.eng_out_base = out_base_q;
    assign done_pulse       = done_c;
    assign sched_idle       = (state == IDLE) && fifo_empty;

endmodule
